// File: rtl/event_synchronizer_rx.sv
// Multi-channel cross-domain event receiver: synchronizes each event line, detects edges,
// queues events in a saturating counter and re-emits them as spaced single-cycle pulses.
module event_synchronizer_rx #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_GAP     = 4,
   parameter int CNT_WIDTH   = 4,
   parameter int EDGE_MODE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] async_in,
   input  logic [NUM_CH-1:0] clear_overflow,
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] overflow
);

   localparam int ARM_MAX = SYNC_STAGES + 1;
   localparam int ARM_W   = $clog2(ARM_MAX + 1);
   localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [GAP_W-1:0]     GAP_RELOAD = GAP_W'(MIN_GAP - 1);

   // Edges seen while the synchronizers still hold reset values are not real events.
   logic [ARM_W-1:0] arm_cnt_q;
   logic [ARM_W-1:0] arm_cnt_d;
   logic             armed;

   assign armed = (arm_cnt_q == ARM_W'(ARM_MAX));

   always_comb begin
      arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         arm_cnt_q <= '0;
      end else begin
         arm_cnt_q <= arm_cnt_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   hist_q;
         logic [CNT_WIDTH-1:0]   cnt_q;
         logic [CNT_WIDTH-1:0]   cnt_d;
         logic [GAP_W-1:0]       gap_q;
         logic [GAP_W-1:0]       gap_d;
         logic                   pulse_q;
         logic                   ovf_q;
         logic                   ovf_d;
         logic                   sync_last;
         logic                   evt;
         logic                   emit;
         logic                   drop;

         assign sync_last = sync_q[SYNC_STAGES-1];

         always_comb begin
            if (EDGE_MODE != 0) begin
               evt = armed & sync_last & ~hist_q;
            end else begin
               evt = armed & (sync_last ^ hist_q);
            end
            emit = ((cnt_q != '0) | evt) & (gap_q == '0);
            // A fresh event that can neither issue nor be queued is lost.
            drop = evt & ~emit & (cnt_q == CNT_MAX);

            cnt_d = cnt_q;
            if (evt & ~emit & ~drop) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end else if (~evt & emit) begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end

            if (emit) begin
               gap_d = GAP_RELOAD;
            end else if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else begin
               gap_d = gap_q;
            end

            ovf_d = drop | (ovf_q & ~clear_overflow[gi]);
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q  <= '0;
               hist_q  <= 1'b0;
               cnt_q   <= '0;
               gap_q   <= '0;
               pulse_q <= 1'b0;
               ovf_q   <= 1'b0;
            end else begin
               sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in[gi]};
               hist_q  <= sync_last;
               cnt_q   <= cnt_d;
               gap_q   <= gap_d;
               pulse_q <= emit;
               ovf_q   <= ovf_d;
            end
         end

         assign pulse_out[gi] = pulse_q;
         assign pending[gi]   = (cnt_q != '0);
         assign overflow[gi]  = ovf_q;
      end
   endgenerate

endmodule

// File: tb/tb_event_synchronizer_rx.sv
// Bench for event_synchronizer_rx: three instances (defaults, small counter / wide gap,
// level mode) with a pulse scoreboard keyed on channel and expected cycle.
module tb_event_synchronizer_rx;

   logic       clk;
   logic       rst;
   logic [3:0] a_def, a_ovf, a_lvl;
   logic [3:0] clr_def, clr_ovf, clr_lvl;
   logic [3:0] po0, po1, po2;
   logic [3:0] pend0, pend1, pend2;
   logic [3:0] ovf0, ovf1, ovf2;

   event_synchronizer_rx u_def (
      .clk(clk), .reset(rst), .async_in(a_def), .clear_overflow(clr_def),
      .pulse_out(po0), .pending(pend0), .overflow(ovf0));

   event_synchronizer_rx #(.CNT_WIDTH(2), .MIN_GAP(8)) u_ovf (
      .clk(clk), .reset(rst), .async_in(a_ovf), .clear_overflow(clr_ovf),
      .pulse_out(po1), .pending(pend1), .overflow(ovf1));

   event_synchronizer_rx #(.EDGE_MODE(1)) u_lvl (
      .clk(clk), .reset(rst), .async_in(a_lvl), .clear_overflow(clr_lvl),
      .pulse_out(po2), .pending(pend2), .overflow(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int d;
      int ch;
      int cyc;
   } sb_ent_t;
   sb_ent_t sb[$];

   typedef struct {
      logic [3:0] tog;
      int         hold;
      logic [3:0] exp_pulse;
      logic [3:0] exp_pend;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("check %s ok: %0h", name, act);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input int ch, input int c);
      sb_ent_t e;
      e.d = d;
      e.ch = ch;
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_neg(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   // Pulse monitor: every observed pulse must match a queued expectation exactly.
   always @(negedge clk) begin
      logic [3:0] p [3];
      int idx;
      p[0] = po0;
      p[1] = po1;
      p[2] = po2;
      for (int d = 0; d < 3; d++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if (p[d][ch] === 1'b1) begin
               idx = -1;
               for (int k = 0; k < sb.size(); k++)
                  if (sb[k].d == d && sb[k].ch == ch && sb[k].cyc == cyc) idx = k;
               n_checks++;
               if (idx >= 0) begin
                  n_pass++;
                  $display("pulse dut%0d ch%0d at cyc %0d ok", d, ch, cyc);
                  sb.delete(idx);
               end else begin
                  $display("FAIL pulse dut%0d ch%0d: got pulse at cyc %0d, expected none", d, ch, cyc);
               end
            end
         end
      end
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].cyc < cyc) begin
            n_checks++;
            $display("FAIL pulse dut%0d ch%0d: got no pulse, expected one at cyc %0d",
                     sb[k].d, sb[k].ch, sb[k].cyc);
            sb.delete(k);
         end
      end
   end

   initial begin
      int c0;
      int c1;
      vecs[0] = '{tog: 4'b1111, hold: 10, exp_pulse: 4'b1111, exp_pend: 4'b0000};
      vecs[1] = '{tog: 4'b0001, hold: 10, exp_pulse: 4'b0001, exp_pend: 4'b0000};
      vecs[2] = '{tog: 4'b0001, hold: 10, exp_pulse: 4'b0001, exp_pend: 4'b0000};
      vecs[3] = '{tog: 4'b0100, hold: 10, exp_pulse: 4'b0100, exp_pend: 4'b0000};
      vecs[4] = '{tog: 4'b1010, hold: 10, exp_pulse: 4'b1010, exp_pend: 4'b0000};
      vecs[5] = '{tog: 4'b1111, hold: 10, exp_pulse: 4'b1111, exp_pend: 4'b0000};

      rst = 1'b1;
      a_def = 4'hF;
      a_ovf = 4'h0;
      a_lvl = 4'h0;
      clr_def = 4'h0;
      clr_ovf = 4'h0;
      clr_lvl = 4'h0;
      repeat (4) step();
      chk("reset pulse_out def", po0, 4'h0);
      chk("reset pending def", pend0, 4'h0);
      chk("reset overflow def", ovf0, 4'h0);
      chk("reset pulse_out ovf", po1, 4'h0);
      chk("reset pending ovf", pend1, 4'h0);
      chk("reset overflow lvl", ovf2, 4'h0);
      rst = 1'b0;
      // Lines already high at reset must stay silent through arming.
      repeat (12) step();
      chk("armed high lines pending", pend0, 4'h0);

      for (int i = 0; i < 6; i++) begin
         logic [3:0] pend_seen;
         step();
         a_def = a_def ^ vecs[i].tog;
         c0 = cyc;
         for (int ch = 0; ch < 4; ch++)
            if (vecs[i].exp_pulse[ch]) push(0, ch, c0 + 3);
         pend_seen = 4'h0;
         repeat (vecs[i].hold) begin
            @(negedge clk);
            pend_seen = pend_seen | pend0;
         end
         chk($sformatf("vec%0d pending seen", i), pend_seen, vecs[i].exp_pend);
         chk($sformatf("vec%0d overflow", i), ovf0, 4'h0);
      end

      // Burst on ch1: toggles 3 cycles apart, pulses forced to 4-cycle spacing.
      step();
      a_def[1] = ~a_def[1];
      c0 = cyc;
      push(0, 1, c0 + 3);
      push(0, 1, c0 + 7);
      push(0, 1, c0 + 11);
      repeat (3) step();
      a_def[1] = ~a_def[1];
      repeat (3) step();
      a_def[1] = ~a_def[1];
      wait_neg(c0 + 6);
      chk("burst pending after 2nd event", {31'd0, pend0[1]}, 1);
      wait_neg(c0 + 10);
      chk("burst pending before 3rd pulse", {31'd0, pend0[1]}, 1);
      wait_neg(c0 + 11);
      chk("burst pending after 3rd pulse", {31'd0, pend0[1]}, 0);
      repeat (8) step();

      // Overflow: 5 events on consecutive cycles into a depth-3 counter.
      step();
      a_ovf[2] = ~a_ovf[2];
      c0 = cyc;
      push(1, 2, c0 + 3);
      push(1, 2, c0 + 11);
      push(1, 2, c0 + 19);
      push(1, 2, c0 + 27);
      repeat (4) begin
         step();
         a_ovf[2] = ~a_ovf[2];
      end
      wait_neg(c0 + 4);
      chk("ovf pending queued", {31'd0, pend1[2]}, 1);
      wait_neg(c0 + 6);
      chk("ovf before drop", {31'd0, ovf1[2]}, 0);
      wait_neg(c0 + 7);
      chk("ovf after drop", {31'd0, ovf1[2]}, 1);
      wait_neg(c0 + 28);
      chk("ovf pending drained", {31'd0, pend1[2]}, 0);
      chk("ovf sticky", {31'd0, ovf1[2]}, 1);
      step();
      clr_ovf[2] = 1'b1;
      c1 = cyc;
      step();
      clr_ovf[2] = 1'b0;
      wait_neg(c1 + 1);
      chk("ovf cleared", {31'd0, ovf1[2]}, 0);
      repeat (15) step();

      // Clear coincident with a second drop: set wins.
      step();
      a_ovf[2] = ~a_ovf[2];
      c1 = cyc;
      push(1, 2, c1 + 3);
      push(1, 2, c1 + 11);
      push(1, 2, c1 + 19);
      push(1, 2, c1 + 27);
      repeat (5) begin
         step();
         a_ovf[2] = ~a_ovf[2];
      end
      repeat (2) step();
      clr_ovf[2] = 1'b1;
      wait_neg(c1 + 7);
      chk("ovf set before coincident clear", {31'd0, ovf1[2]}, 1);
      step();
      clr_ovf[2] = 1'b0;
      wait_neg(c1 + 8);
      chk("ovf set wins over clear", {31'd0, ovf1[2]}, 1);
      wait_neg(c1 + 30);
      step();
      clr_ovf[2] = 1'b1;
      step();
      clr_ovf[2] = 1'b0;
      chk("ovf cleared again", {31'd0, ovf1[2]}, 0);

      // Level mode: only rising edges of ch3 produce pulses.
      step();
      a_lvl[3] = 1'b1;
      c0 = cyc;
      push(2, 3, c0 + 3);
      repeat (6) step();
      a_lvl[3] = 1'b0;
      repeat (6) step();
      a_lvl[3] = 1'b1;
      push(2, 3, c0 + 15);
      repeat (6) step();
      a_lvl[3] = 1'b0;
      repeat (10) step();
      chk("lvl pending idle", pend2, 4'h0);

      // Reset while ch1 holds two queued events.
      step();
      a_def[1] = ~a_def[1];
      c0 = cyc;
      push(0, 1, c0 + 3);
      step();
      a_def[1] = ~a_def[1];
      step();
      a_def[1] = ~a_def[1];
      repeat (3) step();
      chk("midreset pending before", {31'd0, pend0[1]}, 1);
      rst = 1'b1;
      wait_neg(c0 + 6);
      chk("midreset pending after", pend0, 4'h0);
      repeat (3) step();
      chk("midreset overflow ovf dut", ovf1, 4'h0);
      rst = 1'b0;
      repeat (20) step();
      chk("midreset no requeue", pend0, 4'h0);

      step();
      a_def[1] = ~a_def[1];
      push(0, 1, cyc + 3);
      repeat (12) step();

      chk("scoreboard drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
